// File: rtl/rv_ctrl_pkg.sv
// Shared types and constants for the RV32I/RV64I multi-cycle control FSM.
package rv_ctrl_pkg;

   localparam int unsigned ILEN      = 32;
   localparam int unsigned REG_IDX_W = 5;
   localparam int unsigned ALU_ENC_W = 4;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef enum logic [ALU_ENC_W-1:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_XOR  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_AND  = 4'd4,
      ALU_SLL  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SLT  = 4'd7,
      ALU_SLTU = 4'd8,
      ALU_SRA  = 4'd9
   } alu_op_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_MEM,
      ST_WB,
      ST_TRAP
   } ctrl_state_e;

   // Immediate form: I-type, S-type, or a bare shift amount.
   typedef enum logic [1:0] {
      IMM_I,
      IMM_S,
      IMM_SHAMT
   } imm_sel_e;

   // Decoded view of the instruction register.
   typedef struct packed {
      logic     legal;
      logic     is_load;
      logic     is_store;
      logic     src_imm;
      logic     limit_imm;
      imm_sel_e imm_sel;
      alu_op_e  alu_op;
   } decode_t;

   // funct3 to ALU operation; alt selects SUB/SRA over ADD/SRL.
   function automatic alu_op_e funct3_to_alu_op(input logic [2:0] funct3, input logic alt);
      alu_op_e op;
      op = ALU_ADD;
      case (funct3)
         3'b000: op = alt ? ALU_SUB : ALU_ADD;
         3'b001: op = ALU_SLL;
         3'b010: op = ALU_SLT;
         3'b011: op = ALU_SLTU;
         3'b100: op = ALU_XOR;
         3'b101: op = alt ? ALU_SRA : ALU_SRL;
         3'b110: op = ALU_OR;
         3'b111: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/rv_multicycle_control_if.sv
// Control-unit bus: instruction fetch, decoded fields, strobes and data-memory handshake.
interface rv_multicycle_control_if #(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned ALU_OP_W = 4
);
   logic                imem_req;
   logic                imem_ready;
   logic [31:0]         imem_rdata;
   logic [4:0]          rs1;
   logic [4:0]          rs2;
   logic [4:0]          rd;
   logic [XLEN-1:0]     immediate;
   logic [ALU_OP_W-1:0] alu_op;
   logic                alu_src_imm;
   logic                limit_immediate;
   logic                reg_write;
   logic                load_control;
   logic                dmem_req;
   logic                data_mem_write;
   logic                dmem_ready;
   logic                pc_en;
   logic                illegal_instr;

   modport master (
      output imem_req, rs1, rs2, rd, immediate, alu_op, alu_src_imm, limit_immediate,
             reg_write, load_control, dmem_req, data_mem_write, pc_en, illegal_instr,
      input  imem_ready, imem_rdata, dmem_ready
   );

   modport slave (
      input  imem_req, rs1, rs2, rd, immediate, alu_op, alu_src_imm, limit_immediate,
             reg_write, load_control, dmem_req, data_mem_write, pc_en, illegal_instr,
      output imem_ready, imem_rdata, dmem_ready
   );
endinterface

// File: rtl/rv_imm_gen.sv
// Immediate generator: I/S immediates sign-extended to XLEN, shift amounts zero-extended.
module rv_imm_gen
   import rv_ctrl_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [11:0]     ihi_i,   // IR[31:20]
   input  logic [4:0]      slo_i,   // IR[11:7]
   input  imm_sel_e        sel_i,
   output logic [XLEN-1:0] imm_o
);

   logic [11:0] imm12;
   logic [5:0]  shamt;

   // RV64 shifts carry a 6-bit amount, RV32 a 5-bit one.
   assign shamt = (XLEN == 64) ? ihi_i[5:0] : {1'b0, ihi_i[4:0]};

   // Assemble the 12-bit field and widen it.
   always_comb begin
      imm12 = (sel_i == IMM_S) ? {ihi_i[11:5], slo_i} : ihi_i;
      imm_o = (sel_i == IMM_SHAMT) ? XLEN'(shamt) : {{(XLEN-12){imm12[11]}}, imm12};
   end

endmodule

// File: rtl/rv_multicycle_control.sv
// Multi-cycle control FSM: fetch into IR, decode, and sequence EXEC/MEM/WB strobes.
module rv_multicycle_control
   import rv_ctrl_pkg::*;
#(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned ALU_OP_W = 4
) (
   input  logic                    clk,
   input  logic                    resetn,
   rv_multicycle_control_if.master bus
);

   ctrl_state_e     state_q, state_d;
   logic [ILEN-1:0] ir_q, ir_d;
   decode_t         dec;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       shift_imm_ok;

   logic imem_req_c, reg_write_c, load_control_c, dmem_req_c;
   logic data_mem_write_c, pc_en_c, illegal_c;

   assign opcode = ir_q[6:0];
   assign funct3 = ir_q[14:12];
   assign funct7 = ir_q[31:25];

   // Upper shift-immediate bits: zero, or the SRAI pattern.
   if (XLEN == 64) begin : g_shift64
      assign shift_imm_ok = (ir_q[31:26] == 6'b000000) ||
                            ((funct3 == 3'b101) && (ir_q[31:26] == 6'b010000));
   end else begin : g_shift32
      assign shift_imm_ok = (ir_q[31:25] == F7_BASE) ||
                            ((funct3 == 3'b101) && (ir_q[31:25] == F7_ALT));
   end

   // Instruction classification and legality from IR.
   always_comb begin
      dec         = '0;
      dec.imm_sel = IMM_I;
      dec.alu_op  = ALU_ADD;
      case (opcode)
         OPC_OP: begin
            dec.alu_op = funct3_to_alu_op(funct3, funct7[5]);
            dec.legal  = (funct7 == F7_BASE) ||
                         ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
         end
         OPC_OP_IMM: begin
            dec.src_imm = 1'b1;
            if ((funct3 == 3'b001) || (funct3 == 3'b101)) begin
               dec.limit_imm = 1'b1;
               dec.imm_sel   = IMM_SHAMT;
               dec.alu_op    = funct3_to_alu_op(funct3, ir_q[30]);
               dec.legal     = shift_imm_ok;
            end else begin
               dec.alu_op = funct3_to_alu_op(funct3, 1'b0);
               dec.legal  = 1'b1;
            end
         end
         OPC_LOAD: begin
            dec.is_load = 1'b1;
            dec.src_imm = 1'b1;
            dec.legal   = (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) ||
                          ((XLEN == 64) && (funct3 inside {3'b011, 3'b110}));
         end
         OPC_STORE: begin
            dec.is_store = 1'b1;
            dec.src_imm  = 1'b1;
            dec.imm_sel  = IMM_S;
            dec.legal    = (funct3 inside {3'b000, 3'b001, 3'b010}) ||
                           ((XLEN == 64) && (funct3 == 3'b011));
         end
         default: ;
      endcase
   end

   // State and instruction register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
      end
   end

   // Next state and per-state strobes.
   always_comb begin
      state_d          = state_q;
      ir_d             = ir_q;
      imem_req_c       = 1'b0;
      reg_write_c      = 1'b0;
      load_control_c   = 1'b0;
      dmem_req_c       = 1'b0;
      data_mem_write_c = 1'b0;
      pc_en_c          = 1'b0;
      illegal_c        = 1'b0;
      case (state_q)
         ST_IDLE: state_d = ST_FETCH;
         ST_FETCH: begin
            imem_req_c = 1'b1;
            if (bus.imem_ready) begin
               ir_d    = bus.imem_rdata;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: state_d = dec.legal ? ST_EXEC : ST_TRAP;
         ST_EXEC:   state_d = (dec.is_load || dec.is_store) ? ST_MEM : ST_WB;
         ST_MEM: begin
            dmem_req_c       = 1'b1;
            data_mem_write_c = dec.is_store;
            load_control_c   = dec.is_load;
            if (bus.dmem_ready) begin
               // A store retires in its completion cycle, so the PC advances here.
               pc_en_c = dec.is_store;
               state_d = dec.is_store ? ST_FETCH : ST_WB;
            end
         end
         ST_WB: begin
            reg_write_c    = (ir_q[11:7] != 5'd0);
            load_control_c = dec.is_load;
            pc_en_c        = 1'b1;
            state_d        = ST_FETCH;
         end
         ST_TRAP: begin
            illegal_c = 1'b1;
            pc_en_c   = 1'b1;
            state_d   = ST_FETCH;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   rv_imm_gen #(
      .XLEN (XLEN)
   ) u_imm_gen (
      .ihi_i (ir_q[31:20]),
      .slo_i (ir_q[11:7]),
      .sel_i (dec.imm_sel),
      .imm_o (bus.immediate)
   );

   assign bus.rs1             = ir_q[19:15];
   assign bus.rs2             = ir_q[24:20];
   assign bus.rd              = ir_q[11:7];
   assign bus.alu_op          = ALU_OP_W'(dec.alu_op);
   assign bus.alu_src_imm     = dec.src_imm;
   assign bus.limit_immediate = dec.limit_imm;

   assign bus.imem_req       = imem_req_c;
   assign bus.reg_write      = reg_write_c;
   assign bus.load_control   = load_control_c;
   assign bus.dmem_req       = dmem_req_c;
   assign bus.data_mem_write = data_mem_write_c;
   assign bus.pc_en          = pc_en_c;
   assign bus.illegal_instr  = illegal_c;

endmodule

// File: tb/tb_rv_multicycle_control.sv
// Self-checking bench for rv_multicycle_control against a per-instruction behavioural model.
module tb_rv_multicycle_control;

   localparam int unsigned XLEN     = 32;
   localparam int unsigned ALU_OP_W = 4;

   localparam logic [1:0] CLS_ALU = 2'd0;
   localparam logic [1:0] CLS_LD  = 2'd1;
   localparam logic [1:0] CLS_ST  = 2'd2;
   localparam logic [1:0] CLS_ILL = 2'd3;

   typedef struct packed {
      logic        legal;
      logic [1:0]  cls;
      logic [3:0]  aop;
      logic        src_imm;
      logic        lim;
      logic [31:0] imm;
   } exp_t;

   logic clk;
   logic resetn;

   rv_multicycle_control_if #(.XLEN(XLEN), .ALU_OP_W(ALU_OP_W)) bus ();

   rv_multicycle_control #(.XLEN(XLEN), .ALU_OP_W(ALU_OP_W)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // funct3 -> ALU code for the non-alternate operations
   int alu_tbl[8] = '{0, 5, 7, 8, 2, 6, 3, 4};

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] all_outs();
      return {4'b0, bus.imem_req, bus.rs1, bus.rs2, bus.rd, bus.immediate, bus.alu_op,
              bus.alu_src_imm, bus.limit_immediate, bus.reg_write, bus.load_control,
              bus.dmem_req, bus.data_mem_write, bus.pc_en, bus.illegal_instr};
   endfunction

   function automatic logic [52:0] fields();
      return {bus.rs1, bus.rs2, bus.rd, bus.immediate, bus.alu_op,
              bus.alu_src_imm, bus.limit_immediate};
   endfunction

   // Expected decode of one instruction, straight from the ISA rules.
   function automatic exp_t model(input logic [31:0] ins);
      exp_t        e;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [11:0] i12;
      f3        = ins[14:12];
      f7        = ins[31:25];
      i12       = ins[31:20];
      e.legal   = 1'b0;
      e.cls     = CLS_ILL;
      e.aop     = 4'd0;
      e.src_imm = 1'b0;
      e.lim     = 1'b0;
      e.imm     = {{20{i12[11]}}, i12};
      case (ins[6:0])
         7'h33: begin
            e.cls   = CLS_ALU;
            e.legal = (f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5)));
            e.aop   = 4'(alu_tbl[f3]);
            if (f7 == 7'h20) e.aop = (f3 == 3'd0) ? 4'd1 : 4'd9;
         end
         7'h13: begin
            e.cls     = CLS_ALU;
            e.src_imm = 1'b1;
            e.legal   = 1'b1;
            e.aop     = 4'(alu_tbl[f3]);
            if ((f3 == 3'd1) || (f3 == 3'd5)) begin
               e.lim   = 1'b1;
               e.imm   = {27'b0, ins[24:20]};
               e.legal = (f7 == 7'h00) || ((f3 == 3'd5) && (f7 == 7'h20));
               if (f7 == 7'h20) e.aop = 4'd9;
            end
         end
         7'h03: begin
            e.cls     = CLS_LD;
            e.src_imm = 1'b1;
            e.legal   = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
         end
         7'h23: begin
            e.cls     = CLS_ST;
            e.src_imm = 1'b1;
            i12       = {f7, ins[11:7]};
            e.imm     = {{20{i12[11]}}, i12};
            e.legal   = (f3 <= 3'd2);
         end
         default: ;
      endcase
      if (!e.legal) e.cls = CLS_ILL;
      return e;
   endfunction

   // Feed one instruction from a FETCH cycle and check everything up to the next FETCH.
   task automatic run_instr(input logic [31:0] ins, input int iwait, input int dwait);
      exp_t        e;
      int          exp_lat, mem_start, lat, c;
      int          n_ireq, n_dreq, n_dmw, n_stray, n_lc, n_rw, n_pc, n_ill, n_unstable;
      logic        pc_last, rw_last, ill_last, done, is_mem;
      logic [52:0] snap;
      string       t;
      e          = model(ins);
      is_mem     = (e.cls == CLS_LD) || (e.cls == CLS_ST);
      if (e.cls == CLS_ILL)     exp_lat = iwait + 3;
      else if (e.cls == CLS_LD) exp_lat = iwait + 5 + dwait;
      else if (e.cls == CLS_ST) exp_lat = iwait + 4 + dwait;
      else                      exp_lat = iwait + 4;
      mem_start  = iwait + 3;
      n_ireq = 0; n_dreq = 0; n_dmw = 0; n_stray = 0; n_lc = 0;
      n_rw = 0; n_pc = 0; n_ill = 0; n_unstable = 0;
      pc_last = 1'b0; rw_last = 1'b0; ill_last = 1'b0; done = 1'b0;
      snap = '0; lat = 0; c = 0;
      while (!done && c < 64) begin
         bus.imem_ready = (c == iwait) || ((c > iwait) && ($urandom_range(0, 1) == 1));
         bus.imem_rdata = (c == iwait) ? ins : $urandom;
         if (is_mem && (c >= mem_start) && (c < mem_start + dwait)) bus.dmem_ready = 1'b0;
         else if (is_mem && (c == mem_start + dwait))                bus.dmem_ready = 1'b1;
         else                                   bus.dmem_ready = ($urandom_range(0, 1) == 1);
         #1;
         if ((c > iwait) && bus.imem_req) begin
            done = 1'b1;
            lat  = c;
         end else begin
            if (bus.imem_req)                       n_ireq++;
            if (bus.dmem_req)                       n_dreq++;
            if (bus.data_mem_write)                 n_dmw++;
            if (bus.data_mem_write && !bus.dmem_req) n_stray++;
            if (bus.load_control)                   n_lc++;
            if (bus.reg_write)                      n_rw++;
            if (bus.pc_en)                          n_pc++;
            if (bus.illegal_instr)                  n_ill++;
            if (c == iwait + 1) snap = fields();
            else if ((c > iwait + 1) && (fields() !== snap)) n_unstable++;
            if (c == exp_lat - 1) begin
               pc_last  = bus.pc_en;
               rw_last  = bus.reg_write;
               ill_last = bus.illegal_instr;
            end
            @(posedge clk);
            #1;
            c++;
         end
      end
      if (!done) lat = c;
      t = $sformatf("%08h", ins);
      check_eq({t, " latency"},    64'(lat),     64'(exp_lat));
      check_eq({t, " imem_req"},   64'(n_ireq),  64'(iwait + 1));
      check_eq({t, " dmem_req"},   64'(n_dreq),  64'(is_mem ? dwait + 1 : 0));
      check_eq({t, " dmem_write"}, 64'(n_dmw),   64'((e.cls == CLS_ST) ? dwait + 1 : 0));
      check_eq({t, " write_qual"}, 64'(n_stray), 64'(0));
      check_eq({t, " load_ctl"},   64'(n_lc),    64'((e.cls == CLS_LD) ? dwait + 2 : 0));
      check_eq({t, " reg_write"},  64'(n_rw),
               64'((((e.cls == CLS_ALU) || (e.cls == CLS_LD)) && (ins[11:7] != 5'd0)) ? 1 : 0));
      check_eq({t, " rw_last"},    64'(rw_last),
               64'((((e.cls == CLS_ALU) || (e.cls == CLS_LD)) && (ins[11:7] != 5'd0)) ? 1 : 0));
      check_eq({t, " pc_en"},      64'(n_pc),     64'(1));
      check_eq({t, " pc_last"},    64'(pc_last),  64'(1));
      check_eq({t, " illegal"},    64'(n_ill),    64'((e.cls == CLS_ILL) ? 1 : 0));
      check_eq({t, " ill_last"},   64'(ill_last), 64'((e.cls == CLS_ILL) ? 1 : 0));
      check_eq({t, " rs1"},        64'(snap[52:48]), 64'(ins[19:15]));
      check_eq({t, " rs2"},        64'(snap[47:43]), 64'(ins[24:20]));
      check_eq({t, " rd"},         64'(snap[42:38]), 64'(ins[11:7]));
      check_eq({t, " stable"},     64'(n_unstable),  64'(0));
      if (e.legal) begin
         check_eq({t, " immediate"}, 64'(snap[37:6]), 64'(e.imm));
         check_eq({t, " alu_op"},    64'(snap[5:2]),  64'(e.aop));
         check_eq({t, " src_imm"},   64'(snap[1]),    64'(e.src_imm));
         check_eq({t, " limit_imm"}, 64'(snap[0]),    64'(e.lim));
      end
   endtask

   // Abort a load in MEM with reset, then confirm the restart sequence.
   task automatic reset_mid_mem();
      bus.imem_ready = 1'b1;
      bus.imem_rdata = 32'hFFC12283;
      bus.dmem_ready = 1'b0;
      @(posedge clk); #1;
      bus.imem_ready = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check_eq("mem_before_reset dmem_req", 64'(bus.dmem_req), 64'(1));
      #2;
      resetn = 1'b0;
      #1;
      check_eq("async_reset outputs", all_outs(), 64'(0));
      @(posedge clk); #1;
      check_eq("held_reset outputs", all_outs(), 64'(0));
      @(negedge clk);
      resetn = 1'b1;
      #4;
      check_eq("post_reset idle outputs", all_outs(), 64'(0));
      @(posedge clk); #1;
      check_eq("post_reset imem_req", 64'(bus.imem_req), 64'(1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] ins;
      int          kind;
      resetn         = 1'b0;
      bus.imem_ready = 1'b0;
      bus.imem_rdata = '0;
      bus.dmem_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("reset outputs", all_outs(), 64'(0));
      @(negedge clk);
      resetn = 1'b1;
      #4;
      check_eq("idle imem_req", 64'(bus.imem_req), 64'(0));
      @(posedge clk); #1;
      check_eq("first imem_req", 64'(bus.imem_req), 64'(1));

      run_instr(32'h002081B3, 0, 0);   // add x3,x1,x2
      run_instr(32'h402081B3, 1, 0);   // sub
      run_instr(32'h4030D093, 0, 0);   // srai x1,x1,3
      run_instr(32'hFFC12283, 0, 2);   // lw x5,-4(x2)
      run_instr(32'h00512423, 2, 1);   // sw x5,8(x2)
      run_instr(32'hFFFFFFFF, 0, 0);   // illegal
      run_instr(32'h00208033, 0, 0);   // add x0,x1,x2
      run_instr(32'h4030B093, 0, 0);   // bad SLTIU? no: f3=011 legal ALU immediate
      run_instr(32'h40309093, 0, 0);   // slli with SRAI pattern: illegal
      run_instr(32'h00013283, 1, 0);   // ld on RV32: illegal

      reset_mid_mem();

      for (int i = 0; i < 60; i++) begin
         ins  = $urandom;
         kind = $urandom_range(0, 9);
         if (kind <= 2)      ins[6:0] = 7'h33;
         else if (kind <= 5) ins[6:0] = 7'h13;
         else if (kind <= 7) ins[6:0] = 7'h03;
         else if (kind == 8) ins[6:0] = 7'h23;
         case ($urandom_range(0, 3))
            0, 1:    ins[31:25] = 7'h00;
            2:       ins[31:25] = 7'h20;
            default: ;
         endcase
         run_instr(ins, $urandom_range(0, 2), $urandom_range(0, 3));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
